ita_tile_sequencer: RTL and testbench

ITA_TILE_SEQUENCER -- requirements
Module: ita_tile_sequencer

---
 rtl/ita_tile_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_ita_tile_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_tile_sequencer.sv
// Tile sequencer for the ITA matmul engine: walks output tiles, inner tiles and
// beats, gates operand handshakes on output back-pressure, and emits lane masks.
module ita_tile_sequencer #(
    parameter int M          = 64,
    parameter int N          = 16,
    parameter int DIM_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [DIM_W-1:0] rows_i,
    input  logic [DIM_W-1:0] cols_i,
    input  logic [DIM_W-1:0] tiles_y_i,
    input  logic [DIM_W-1:0] tiles_x_i,
    input  logic [DIM_W-1:0] tiles_inner_i,
    input  logic             col_major_i,
    input  logic [1:0]       mask_type_i,
    input  logic [DIM_W-1:0] mask_off_i,
    input  logic             inp_valid_i,
    input  logic             weight_valid_i,
    input  logic             bias_valid_i,
    output logic             inp_ready_o,
    output logic             weight_ready_o,
    output logic             bias_ready_o,
    input  logic             oup_valid_i,
    input  logic             oup_ready_i,
    output logic             calc_en_o,
    output logic [DIM_W-1:0] tile_x_o,
    output logic [DIM_W-1:0] tile_y_o,
    output logic [DIM_W-1:0] inner_tile_o,
    output logic             first_inner_o,
    output logic             last_inner_o,
    output logic [N-1:0]     lane_en_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned BEATS = (M * M) / N;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LOGM  = (M > 1) ? $clog2(M) : 1;
    // Coordinates are carried wide enough that tile*M + offset + mask_off never wraps.
    localparam int unsigned XW    = DIM_W + LOGM + 2;

    localparam logic [CW-1:0] BEAT_LAST = CW'(BEATS - 1);
    localparam logic [OW-1:0] DEPTH_C   = OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_beat;
    logic [DIM_W-1:0] r_tile_x;
    logic [DIM_W-1:0] r_tile_y;
    logic [DIM_W-1:0] r_inner;
    logic [OW-1:0]    r_out;

    logic [DIM_W-1:0] r_rows;
    logic [DIM_W-1:0] r_cols;
    logic [DIM_W-1:0] r_tiles_y;
    logic [DIM_W-1:0] r_tiles_x;
    logic [DIM_W-1:0] r_tiles_inner;
    logic             r_col_major;
    logic [1:0]       r_mask_type;
    logic [DIM_W-1:0] r_mask_off;

    logic             w_run;
    logic             w_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_last_beat;
    logic             w_last_inner;
    logic             w_last_x;
    logic             w_last_y;
    logic             w_zero_cfg;
    logic [XW-1:0]    w_row;
    logic [XW-1:0]    w_col_base;
    logic [XW-1:0]    w_k;
    logic             w_ok;
    logic [N-1:0]     w_lane_en;

    assign w_run        = (r_state == S_RUN);
    assign w_fire       = rst_ni && w_run && inp_valid_i && weight_valid_i && bias_valid_i
                          && (r_out < DEPTH_C);
    assign w_last_beat  = (r_beat == BEAT_LAST);
    assign w_last_inner = (r_inner == r_tiles_inner - 1'b1);
    assign w_last_x     = (r_tile_x == r_tiles_x - 1'b1);
    assign w_last_y     = (r_tile_y == r_tiles_y - 1'b1);
    assign w_push       = w_fire && w_last_inner;
    assign w_pop        = oup_valid_i && oup_ready_i && (r_out != '0);
    assign w_zero_cfg   = (tiles_y_i == '0) || (tiles_x_i == '0) || (tiles_inner_i == '0);

    assign w_row      = XW'(r_tile_y) * XW'(M) + (XW'(r_beat) % XW'(M));
    assign w_col_base = XW'(r_tile_x) * XW'(M) + (XW'(r_beat) / XW'(M)) * XW'(N);

    // Padding always applies; the triangular mask only on the last inner tile.
    always_comb begin
        w_lane_en = '0;
        w_k       = '0;
        w_ok      = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            w_k  = w_col_base + XW'(i);
            w_ok = (w_row < XW'(r_rows)) && (w_k < XW'(r_cols));
            if (w_last_inner) begin
                case (r_mask_type)
                    2'd1:    w_ok = w_ok && (w_k <= w_row + XW'(r_mask_off));
                    2'd2:    w_ok = w_ok && (w_k + XW'(r_mask_off) >= w_row);
                    default: w_ok = w_ok;
                endcase
            end
            w_lane_en[i] = w_fire && w_ok;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state       <= S_IDLE;
            r_beat        <= '0;
            r_tile_x      <= '0;
            r_tile_y      <= '0;
            r_inner       <= '0;
            r_out         <= '0;
            r_rows        <= '0;
            r_cols        <= '0;
            r_tiles_y     <= '0;
            r_tiles_x     <= '0;
            r_tiles_inner <= '0;
            r_col_major   <= 1'b0;
            r_mask_type   <= '0;
            r_mask_off    <= '0;
        end else begin
            if (w_push && !w_pop) begin
                r_out <= r_out + 1'b1;
            end else if (!w_push && w_pop) begin
                r_out <= r_out - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_rows        <= rows_i;
                        r_cols        <= cols_i;
                        r_tiles_y     <= tiles_y_i;
                        r_tiles_x     <= tiles_x_i;
                        r_tiles_inner <= tiles_inner_i;
                        r_col_major   <= col_major_i;
                        r_mask_type   <= mask_type_i;
                        r_mask_off    <= mask_off_i;
                        r_beat        <= '0;
                        r_tile_x      <= '0;
                        r_tile_y      <= '0;
                        r_inner       <= '0;
                        r_state       <= w_zero_cfg ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_fire) begin
                        if (!w_last_beat) begin
                            r_beat <= r_beat + 1'b1;
                        end else begin
                            r_beat <= '0;
                            if (!w_last_inner) begin
                                r_inner <= r_inner + 1'b1;
                            end else begin
                                r_inner <= '0;
                                if (!r_col_major) begin
                                    if (!w_last_x) begin
                                        r_tile_x <= r_tile_x + 1'b1;
                                    end else begin
                                        r_tile_x <= '0;
                                        if (!w_last_y) begin
                                            r_tile_y <= r_tile_y + 1'b1;
                                        end else begin
                                            r_tile_y <= '0;
                                            r_state  <= S_DRAIN;
                                        end
                                    end
                                end else begin
                                    if (!w_last_y) begin
                                        r_tile_y <= r_tile_y + 1'b1;
                                    end else begin
                                        r_tile_y <= '0;
                                        if (!w_last_x) begin
                                            r_tile_x <= r_tile_x + 1'b1;
                                        end else begin
                                            r_tile_x <= '0;
                                            r_state  <= S_DRAIN;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_out == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign inp_ready_o    = w_fire;
    assign weight_ready_o = w_fire;
    assign bias_ready_o   = w_fire;
    assign calc_en_o      = w_fire;
    assign tile_x_o       = r_tile_x;
    assign tile_y_o       = r_tile_y;
    assign inner_tile_o   = r_inner;
    assign first_inner_o  = w_run && (r_inner == '0);
    assign last_inner_o   = w_run && w_last_inner;
    assign lane_en_o      = w_lane_en;
    assign busy_o         = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done_o         = (r_state == S_DONE);

endmodule

// File: tb/tb_ita_tile_sequencer.sv
// Bench for ita_tile_sequencer (M=4, N=2): directed table, stall/clear/reset
// sequences, and randomized jobs checked against a loop-enumerated beat list.
module tb_ita_tile_sequencer;

    localparam int M     = 4;
    localparam int N     = 2;
    localparam int DIM_W = 16;
    localparam int FD    = 4;
    localparam int BEATS = M * M / N;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic             clear_i;
    logic [DIM_W-1:0] rows_i;
    logic [DIM_W-1:0] cols_i;
    logic [DIM_W-1:0] tiles_y_i;
    logic [DIM_W-1:0] tiles_x_i;
    logic [DIM_W-1:0] tiles_inner_i;
    logic             col_major_i;
    logic [1:0]       mask_type_i;
    logic [DIM_W-1:0] mask_off_i;
    logic             inp_valid_i;
    logic             weight_valid_i;
    logic             bias_valid_i;
    logic             inp_ready_o;
    logic             weight_ready_o;
    logic             bias_ready_o;
    logic             oup_valid_i;
    logic             oup_ready_i;
    logic             calc_en_o;
    logic [DIM_W-1:0] tile_x_o;
    logic [DIM_W-1:0] tile_y_o;
    logic [DIM_W-1:0] inner_tile_o;
    logic             first_inner_o;
    logic             last_inner_o;
    logic [N-1:0]     lane_en_o;
    logic             busy_o;
    logic             done_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int rows, cols, ty, tx, ti, cm, mask, off;
    } cfg_t;

    typedef struct {
        int           tx, ty, inner;
        logic [N-1:0] lane;
    } beat_t;

    typedef struct {
        cfg_t         c;
        int           exp_n;
        int           beat;
        logic [N-1:0] lane;
        int           tx, ty;
    } vec_t;

    beat_t        exp_q[$];
    logic [N-1:0] obs_lane[0:255];
    int           obs_tx[0:255];
    int           obs_ty[0:255];

    ita_tile_sequencer #(.M(M), .N(N), .DIM_W(DIM_W), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
        .rows_i(rows_i), .cols_i(cols_i), .tiles_y_i(tiles_y_i), .tiles_x_i(tiles_x_i),
        .tiles_inner_i(tiles_inner_i), .col_major_i(col_major_i),
        .mask_type_i(mask_type_i), .mask_off_i(mask_off_i),
        .inp_valid_i(inp_valid_i), .weight_valid_i(weight_valid_i), .bias_valid_i(bias_valid_i),
        .inp_ready_o(inp_ready_o), .weight_ready_o(weight_ready_o), .bias_ready_o(bias_ready_o),
        .oup_valid_i(oup_valid_i), .oup_ready_i(oup_ready_i),
        .calc_en_o(calc_en_o), .tile_x_o(tile_x_o), .tile_y_o(tile_y_o),
        .inner_tile_o(inner_tile_o), .first_inner_o(first_inner_o), .last_inner_o(last_inner_o),
        .lane_en_o(lane_en_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_cfg(input cfg_t c);
        rows_i        = DIM_W'(c.rows);
        cols_i        = DIM_W'(c.cols);
        tiles_y_i     = DIM_W'(c.ty);
        tiles_x_i     = DIM_W'(c.tx);
        tiles_inner_i = DIM_W'(c.ti);
        col_major_i   = c.cm[0];
        mask_type_i   = 2'(c.mask);
        mask_off_i    = DIM_W'(c.off);
    endtask

    task automatic scramble_cfg();
        rows_i        = DIM_W'($urandom);
        cols_i        = DIM_W'($urandom);
        tiles_y_i     = DIM_W'($urandom);
        tiles_x_i     = DIM_W'($urandom);
        tiles_inner_i = DIM_W'($urandom);
        col_major_i   = 1'($urandom);
        mask_type_i   = 2'($urandom);
        mask_off_i    = DIM_W'($urandom);
    endtask

    task automatic drive_hs(input bit rnd);
        if (rnd) begin
            inp_valid_i    = ($urandom_range(0, 3) != 0);
            weight_valid_i = ($urandom_range(0, 3) != 0);
            bias_valid_i   = ($urandom_range(0, 3) != 0);
            oup_valid_i    = ($urandom_range(0, 3) != 0);
            oup_ready_i    = ($urandom_range(0, 2) != 0);
        end else begin
            inp_valid_i    = 1'b1;
            weight_valid_i = 1'b1;
            bias_valid_i   = 1'b1;
            oup_valid_i    = 1'b1;
            oup_ready_i    = 1'b1;
        end
    endtask

    // Ordered list of every beat of a job, enumerated straight from the tile/beat rules.
    task automatic build_expected(input cfg_t c);
        int na, nb, x, y, r, k;
        bit ok;
        logic [N-1:0] ln;
        beat_t b;
        exp_q.delete();
        if (c.ty == 0 || c.tx == 0 || c.ti == 0) return;
        na = c.cm ? c.tx : c.ty;
        nb = c.cm ? c.ty : c.tx;
        for (int a = 0; a < na; a++)
            for (int bb = 0; bb < nb; bb++)
                for (int inr = 0; inr < c.ti; inr++)
                    for (int cc = 0; cc < BEATS; cc++) begin
                        x = c.cm ? a : bb;
                        y = c.cm ? bb : a;
                        r = y * M + cc % M;
                        ln = '0;
                        for (int i = 0; i < N; i++) begin
                            k  = x * M + (cc / M) * N + i;
                            ok = (r < c.rows) && (k < c.cols);
                            if (inr == c.ti - 1) begin
                                if (c.mask == 1) ok = ok && (k <= r + c.off);
                                else if (c.mask == 2) ok = ok && (k + c.off >= r);
                            end
                            ln[i] = ok;
                        end
                        b.tx = x; b.ty = y; b.inner = inr; b.lane = ln;
                        exp_q.push_back(b);
                    end
    endtask

    // phase: 0 idle, 1 run, 2 drain, 3 done; m_out = outputs accepted but not yet popped.
    task automatic run_job(input cfg_t c, input bit rnd, output int nf);
        int phase, nxt, m_out, idx, cyc, budget;
        bit f, push, pop;
        beat_t e;
        build_expected(c);
        set_cfg(c);
        start_i = 1'b1;
        clear_i = 1'b0;
        drive_hs(rnd);
        #1;
        chk("start_busy", busy_o, 0);
        chk("start_calc", calc_en_o, 0);
        tick();
        phase  = (exp_q.size() == 0) ? 3 : 1;
        m_out  = 0;
        idx    = 0;
        cyc    = 0;
        budget = 20 * exp_q.size() + 100;
        e      = '{default: 0};
        while (phase != 0 && cyc < budget) begin
            if (rnd) begin
                scramble_cfg();
                start_i = 1'($urandom);
            end else begin
                start_i = 1'b0;
            end
            drive_hs(rnd);
            f = (phase == 1) && inp_valid_i && weight_valid_i && bias_valid_i && (m_out < FD);
            #1;
            chk("calc_en", calc_en_o, f);
            chk("readies", {inp_ready_o, weight_ready_o, bias_ready_o}, {3{f}});
            chk("busy", busy_o, (phase == 1 || phase == 2));
            chk("done", done_o, (phase == 3));
            if (phase == 1) begin
                e = exp_q[idx];
                chk("tile_x", tile_x_o, e.tx);
                chk("tile_y", tile_y_o, e.ty);
                chk("inner", inner_tile_o, e.inner);
                chk("first_inner", first_inner_o, (e.inner == 0));
                chk("last_inner", last_inner_o, (e.inner == c.ti - 1));
            end else begin
                chk("first_inner_off", first_inner_o, 0);
                chk("last_inner_off", last_inner_o, 0);
            end
            if (f) begin
                chk("lane_en", lane_en_o, e.lane);
                obs_lane[idx] = lane_en_o;
                obs_tx[idx]   = int'(tile_x_o);
                obs_ty[idx]   = int'(tile_y_o);
                idx++;
            end else begin
                chk("lane_en_idle", lane_en_o, 0);
            end
            push = f && (e.inner == c.ti - 1);
            pop  = oup_valid_i && oup_ready_i && (m_out > 0);
            nxt  = phase;
            if (phase == 1 && f && idx == exp_q.size()) nxt = 2;
            else if (phase == 2 && m_out == 0) nxt = 3;
            else if (phase == 3) nxt = 0;
            m_out = m_out + int'(push) - int'(pop);
            tick();
            phase = nxt;
            cyc++;
        end
        if (phase != 0) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got phase=%0d after %0d cycles, expected idle", phase, cyc);
            clear_i = 1'b1;
            tick();
            clear_i = 1'b0;
        end
        start_i = 1'b0;
        nf = idx;
    endtask

    initial begin
        vec_t tbl[$];
        cfg_t c;
        int   nf;

        // {rows,cols,ty,tx,ti,cm,mask,off}, beat count, probe beat, lane_en, tile_x, tile_y
        tbl.push_back('{'{4, 4, 1, 1, 1, 0, 1, 0},  8,  0, 2'b01, 0, 0});
        tbl.push_back('{'{4, 4, 1, 1, 1, 0, 1, 0},  8,  4, 2'b00, 0, 0});
        tbl.push_back('{'{4, 4, 1, 1, 1, 0, 1, 0},  8,  7, 2'b11, 0, 0});
        tbl.push_back('{'{4, 4, 1, 1, 1, 0, 2, 0},  8,  0, 2'b11, 0, 0});
        tbl.push_back('{'{4, 4, 1, 1, 1, 0, 2, 0},  8,  3, 2'b00, 0, 0});
        tbl.push_back('{'{4, 4, 1, 1, 1, 0, 2, 0},  8,  7, 2'b10, 0, 0});
        tbl.push_back('{'{5, 3, 2, 1, 1, 0, 0, 0}, 16,  4, 2'b01, 0, 0});
        tbl.push_back('{'{5, 3, 2, 1, 1, 0, 0, 0}, 16,  8, 2'b11, 0, 1});
        tbl.push_back('{'{5, 3, 2, 1, 1, 0, 0, 0}, 16,  9, 2'b00, 0, 1});
        tbl.push_back('{'{5, 3, 2, 1, 1, 0, 0, 0}, 16, 12, 2'b01, 0, 1});
        tbl.push_back('{'{4, 4, 1, 1, 1, 0, 1, 1},  8,  5, 2'b01, 0, 0});
        tbl.push_back('{'{4, 4, 1, 1, 2, 0, 1, 0}, 16,  0, 2'b11, 0, 0});
        tbl.push_back('{'{4, 4, 1, 1, 2, 0, 1, 0}, 16,  8, 2'b01, 0, 0});
        tbl.push_back('{'{8, 8, 2, 2, 1, 1, 0, 0}, 32,  8, 2'b11, 0, 1});
        tbl.push_back('{'{8, 8, 2, 2, 1, 1, 0, 0}, 32, 16, 2'b11, 1, 0});
        tbl.push_back('{'{8, 8, 2, 2, 1, 0, 0, 0}, 32,  8, 2'b11, 1, 0});
        tbl.push_back('{'{8, 8, 2, 2, 1, 0, 0, 0}, 32, 31, 2'b11, 1, 1});
        tbl.push_back('{'{4, 4, 1, 1, 1, 0, 3, 0},  8,  0, 2'b11, 0, 0});
        tbl.push_back('{'{4, 4, 1, 0, 1, 0, 0, 0},  0, -1, 2'b00, 0, 0});

        // Reset with launch and valids asserted must leave everything quiet.
        rst_ni = 1'b0;
        clear_i = 1'b0;
        start_i = 1'b1;
        set_cfg('{8, 8, 2, 2, 1, 0, 0, 0});
        drive_hs(0);
        tick(); tick(); tick();
        #1;
        chk("rst_calc", calc_en_o, 0);
        chk("rst_ready", {inp_ready_o, weight_ready_o, bias_ready_o}, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_lane", lane_en_o, 0);
        chk("rst_tiles", {tile_x_o, tile_y_o}, 0);
        chk("rst_inner", {inner_tile_o, 14'd0, first_inner_o, last_inner_o}, 0);
        rst_ni  = 1'b1;
        start_i = 1'b0;
        tick();

        foreach (tbl[t]) begin
            run_job(tbl[t].c, 0, nf);
            chk("tbl_beats", nf, tbl[t].exp_n);
            if (tbl[t].beat >= 0) begin
                chk("tbl_lane", obs_lane[tbl[t].beat], tbl[t].lane);
                chk("tbl_tx", obs_tx[tbl[t].beat], tbl[t].tx);
                chk("tbl_ty", obs_ty[tbl[t].beat], tbl[t].ty);
            end
        end

        // Back-pressure: four last-inner beats fill the output allowance.
        set_cfg('{4, 4, 1, 1, 2, 0, 0, 0});
        drive_hs(0);
        oup_ready_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        nf = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            nf += int'(calc_en_o);
            if (i == 13) chk("stall_readies", {inp_ready_o, weight_ready_o, bias_ready_o}, 0);
            tick();
        end
        chk("stall_fires", nf, 12);
        oup_ready_i = 1'b1;
        #1; chk("pop_cycle_calc", calc_en_o, 0); tick();
        #1; chk("fire_and_pop_calc", calc_en_o, 1); tick();
        oup_ready_i = 1'b0;
        #1; chk("refill_calc", calc_en_o, 1); tick();
        #1; chk("restall_calc", calc_en_o, 0);
        chk("restall_inner", inner_tile_o, 1);
        tick();

        // Abort wins over a simultaneous launch.
        clear_i = 1'b1;
        start_i = 1'b1;
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("clear_busy", busy_o, 0);
        chk("clear_done", done_o, 0);
        chk("clear_calc", calc_en_o, 0);
        chk("clear_inner", inner_tile_o, 0);
        tick();
        #1;
        chk("clear_done2", done_o, 0);
        chk("clear_busy2", busy_o, 0);
        tick();
        run_job('{8, 8, 2, 2, 1, 0, 0, 0}, 0, nf);
        chk("after_clear_beats", nf, 32);

        // Synchronous reset in the middle of a job.
        set_cfg('{8, 8, 2, 2, 1, 0, 0, 0});
        drive_hs(0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("midrun_tile_x", tile_x_o, 1);
        rst_ni = 1'b0;
        tick();
        #1;
        chk("midrst_calc", calc_en_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_tiles", {tile_x_o, tile_y_o}, 0);
        chk("midrst_inner", inner_tile_o, 0);
        rst_ni = 1'b1;
        tick();

        // Randomized jobs with random handshakes and config churn after launch.
        for (int j = 0; j < 24; j++) begin
            c.rows = $urandom_range(0, 12);
            c.cols = $urandom_range(0, 12);
            c.ty   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
            c.tx   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
            c.ti   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
            c.cm   = $urandom_range(0, 1);
            c.mask = $urandom_range(0, 3);
            c.off  = $urandom_range(0, 5);
            run_job(c, 1, nf);
            chk("rand_beats", nf, c.ty * c.tx * c.ti * BEATS);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
